// File: rtl/matmul_result_writer.sv
// Drains a captured MAT_MUL_SIZE x MAT_MUL_SIZE result matrix into memory, one row per write,
// with ready/valid back-pressure and wrap-around addressing.
module matmul_result_writer #(
    parameter int DWIDTH       = 16,
    parameter int AWIDTH       = 7,
    parameter int MAT_MUL_SIZE = 4
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         done_mat_mul,
    input  logic [MAT_MUL_SIZE*MAT_MUL_SIZE*2*DWIDTH-1:0] matrixC_flat,
    input  logic [7:0]                                   final_mat_mul_size,
    input  logic [AWIDTH-1:0]                            c_base,
    output logic [AWIDTH-1:0]                            c_addr,
    output logic [MAT_MUL_SIZE*2*DWIDTH-1:0]             c_data,
    output logic                                         c_wen,
    input  logic                                         c_ready,
    output logic                                         drain_done
);

    localparam int EW = 2 * DWIDTH;
    localparam int NE = MAT_MUL_SIZE * MAT_MUL_SIZE;
    localparam int SW = $clog2(MAT_MUL_SIZE + 1);
    localparam int RW = MAT_MUL_SIZE * EW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                  state_r, state_s;
    logic [SW-1:0]           row_r, row_s;
    logic [SW-1:0]           size_r, size_s, size_in_s;
    logic [AWIDTH-1:0]       base_r, base_s;
    logic [NE-1:0][EW-1:0]   snap_r;
    logic                    capture_s;
    logic [AWIDTH-1:0]       c_addr_r, c_addr_s;
    logic [RW-1:0]           c_data_r, c_data_s;
    logic                    c_wen_r, c_wen_s;
    logic                    drain_done_r, drain_done_s;

    // Pack row r of matrix m, zeroing columns at or beyond the active size.
    function automatic logic [RW-1:0] row_word(input logic [NE-1:0][EW-1:0] m,
                                               input logic [SW-1:0] r,
                                               input logic [SW-1:0] sz);
        logic [RW-1:0] w;
        w = {RW{1'b0}};
        for (int j = 0; j < MAT_MUL_SIZE; j++) begin
            if (SW'(j) < sz) begin
                w[j*EW +: EW] = m[int'(r) * MAT_MUL_SIZE + j];
            end else begin
                w[j*EW +: EW] = {EW{1'b0}};
            end
        end
        return w;
    endfunction

    assign size_in_s = (final_mat_mul_size > 8'(MAT_MUL_SIZE)) ? SW'(MAT_MUL_SIZE)
                                                                : final_mat_mul_size[SW-1:0];

    // Next-state and next-output logic; outputs are computed one edge early so they can be registered.
    always_comb begin
        state_s      = state_r;
        row_s        = row_r;
        size_s       = size_r;
        base_s       = base_r;
        capture_s    = 1'b0;
        c_addr_s     = c_addr_r;
        c_data_s     = {RW{1'b0}};
        c_wen_s      = 1'b0;
        drain_done_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (done_mat_mul) begin
                    capture_s = 1'b1;
                    size_s    = size_in_s;
                    base_s    = c_base;
                    row_s     = {SW{1'b0}};
                    if (size_in_s == {SW{1'b0}}) begin
                        state_s      = DONE;
                        drain_done_s = 1'b1;
                    end else begin
                        state_s  = WRITE;
                        c_wen_s  = 1'b1;
                        c_addr_s = c_base;
                        c_data_s = row_word(matrixC_flat, {SW{1'b0}}, size_in_s);
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WRITE: begin
                if (c_ready) begin
                    row_s = row_r + SW'(1);
                    if (row_r == size_r - SW'(1)) begin
                        state_s      = DONE;
                        drain_done_s = 1'b1;
                    end else begin
                        c_wen_s  = 1'b1;
                        c_addr_s = base_r + AWIDTH'(row_r + SW'(1));
                        c_data_s = row_word(snap_r, row_r + SW'(1), size_r);
                    end
                end else begin
                    c_wen_s  = 1'b1;
                    c_data_s = c_data_r;
                end
            end
            DONE: begin
                if (done_mat_mul) begin
                    drain_done_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counters, snapshot and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            row_r        <= {SW{1'b0}};
            size_r       <= {SW{1'b0}};
            base_r       <= {AWIDTH{1'b0}};
            snap_r       <= {(NE*EW){1'b0}};
            c_addr_r     <= {AWIDTH{1'b0}};
            c_data_r     <= {RW{1'b0}};
            c_wen_r      <= 1'b0;
            drain_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            row_r        <= row_s;
            size_r       <= size_s;
            base_r       <= base_s;
            c_addr_r     <= c_addr_s;
            c_data_r     <= c_data_s;
            c_wen_r      <= c_wen_s;
            drain_done_r <= drain_done_s;
            if (capture_s) begin
                snap_r <= matrixC_flat;
            end else begin
                snap_r <= snap_r;
            end
        end
    end

    assign c_addr     = c_addr_r;
    assign c_data     = c_data_r;
    assign c_wen      = c_wen_r;
    assign drain_done = drain_done_r;

endmodule

// File: tb/tb_matmul_result_writer.sv
// Directed bench for matmul_result_writer: table of drain scenarios plus hand-written
// reset-abort and early done-fall sequences.
module tb_matmul_result_writer;

    logic         clk;
    logic         reset;
    logic         done_mat_mul;
    logic [511:0] matrixC_flat;
    logic [7:0]   final_mat_mul_size;
    logic [6:0]   c_base;
    logic [6:0]   c_addr;
    logic [127:0] c_data;
    logic         c_wen;
    logic         c_ready;
    logic         drain_done;

    int checks = 0;
    int errors = 0;

    matmul_result_writer #(.DWIDTH(16), .AWIDTH(7), .MAT_MUL_SIZE(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .done_mat_mul       (done_mat_mul),
        .matrixC_flat       (matrixC_flat),
        .final_mat_mul_size (final_mat_mul_size),
        .c_base             (c_base),
        .c_addr             (c_addr),
        .c_data             (c_data),
        .c_wen              (c_wen),
        .c_ready            (c_ready),
        .drain_done         (drain_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] size;
        logic [6:0] base;
        logic [7:0] mask;       // bit k = c_ready on the k-th cycle after capture (wraps mod 8)
        int         exp_rows;
        int         exp_wen_cycles;
    } case_t;

    case_t cases [8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] make_matrix(input int off);
        logic [511:0] m;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[(4*r+c)*32 +: 32] = 32'(16*r + c + off);
        return m;
    endfunction

    function automatic logic [127:0] exp_row(input int r, input int sz, input int off);
        logic [127:0] v;
        v = 128'd0;
        for (int j = 0; j < 4; j++)
            if (j < sz) v[j*32 +: 32] = 32'(16*r + j + off);
        return v;
    endfunction

    task automatic run_case(input case_t tc, input int off);
        int           sz;
        int           rows;
        int           wen_cycles;
        logic         prev_stall;
        logic [6:0]   prev_addr;
        logic [127:0] prev_data;
        logic [6:0]   exp_addr;
        logic         finished;
        sz         = (tc.size > 8'd4) ? 4 : int'(tc.size);
        rows       = 0;
        wen_cycles = 0;
        prev_stall = 1'b0;
        prev_addr  = 7'd0;
        prev_data  = 128'd0;
        finished   = 1'b0;
        matrixC_flat       = make_matrix(off);
        final_mat_mul_size = tc.size;
        c_base             = tc.base;
        c_ready            = tc.mask[0];
        done_mat_mul       = 1'b1;
        tick();
        // Scramble the inputs right after capture; the drain must use the snapshot.
        matrixC_flat       = ~make_matrix(off);
        final_mat_mul_size = 8'd1;
        c_base             = 7'h55;
        for (int k = 0; k < 40; k++) begin
            if (drain_done) begin
                finished = 1'b1;
                break;
            end
            if (c_wen) begin
                wen_cycles++;
                exp_addr = tc.base + 7'(rows);
                chk("wr_addr", c_addr, exp_addr);
                chk("wr_data", c_data, exp_row(rows, sz, off));
                if (prev_stall) begin
                    chk("stall_addr", c_addr, prev_addr);
                    chk("stall_data", c_data, prev_data);
                end
                prev_addr  = c_addr;
                prev_data  = c_data;
                prev_stall = !c_ready;
                if (c_ready) rows++;
            end else begin
                chk("data_zero_idle", c_data, 128'd0);
                prev_stall = 1'b0;
            end
            tick();
            c_ready = tc.mask[(k + 1) % 8];
        end
        chk("drain_timeout", finished, 1'b1);
        chk("rows_written", rows, tc.exp_rows);
        chk("wen_cycles", wen_cycles, tc.exp_wen_cycles);
        chk("done_wen", c_wen, 1'b0);
        chk("done_data", c_data, 128'd0);
        if (tc.exp_rows > 0) begin
            exp_addr = tc.base + 7'(tc.exp_rows - 1);
            chk("addr_hold", c_addr, exp_addr);
        end
        tick();
        chk("done_hold", drain_done, 1'b1);
        chk("done_hold_wen", c_wen, 1'b0);
        done_mat_mul = 1'b0;
        tick();
        chk("done_fall", drain_done, 1'b0);
        chk("idle_wen", c_wen, 1'b0);
    endtask

    initial begin
        cases[0] = '{size: 8'd4, base: 7'h10, mask: 8'hFF, exp_rows: 4, exp_wen_cycles: 4};
        cases[1] = '{size: 8'd2, base: 7'h20, mask: 8'hFF, exp_rows: 2, exp_wen_cycles: 2};
        cases[2] = '{size: 8'd4, base: 7'h30, mask: 8'hE9, exp_rows: 4, exp_wen_cycles: 7};
        cases[3] = '{size: 8'd4, base: 7'h7E, mask: 8'hFF, exp_rows: 4, exp_wen_cycles: 4};
        cases[4] = '{size: 8'd9, base: 7'h05, mask: 8'hFF, exp_rows: 4, exp_wen_cycles: 4};
        cases[5] = '{size: 8'd0, base: 7'h40, mask: 8'hFF, exp_rows: 0, exp_wen_cycles: 0};
        cases[6] = '{size: 8'd1, base: 7'h7F, mask: 8'h06, exp_rows: 1, exp_wen_cycles: 2};
        cases[7] = '{size: 8'd3, base: 7'h00, mask: 8'h55, exp_rows: 3, exp_wen_cycles: 5};

        reset              = 1'b1;
        done_mat_mul       = 1'b0;
        matrixC_flat       = 512'd0;
        final_mat_mul_size = 8'd0;
        c_base             = 7'd0;
        c_ready            = 1'b0;
        #1;
        chk("rst_wen", c_wen, 1'b0);
        chk("rst_done", drain_done, 1'b0);
        chk("rst_addr", c_addr, 7'd0);
        chk("rst_data", c_data, 128'd0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("idle_no_start", c_wen, 1'b0);

        for (int i = 0; i < 8; i++) begin
            run_case(cases[i], i * 256);
        end

        // done_mat_mul drops during WRITE: drain finishes, DONE for one cycle, then IDLE.
        matrixC_flat       = make_matrix(32'h300);
        final_mat_mul_size = 8'd3;
        c_base             = 7'h08;
        c_ready            = 1'b1;
        done_mat_mul       = 1'b1;
        tick();
        done_mat_mul = 1'b0;
        chk("early_r0_addr", c_addr, 7'h08);
        chk("early_r0_data", c_data, exp_row(0, 3, 32'h300));
        tick();
        chk("early_r1_addr", c_addr, 7'h09);
        tick();
        chk("early_r2_addr", c_addr, 7'h0A);
        chk("early_r2_data", c_data, exp_row(2, 3, 32'h300));
        tick();
        chk("early_done", drain_done, 1'b1);
        chk("early_done_wen", c_wen, 1'b0);
        tick();
        chk("early_idle", drain_done, 1'b0);

        // Reset after the second accepted write aborts the drain without a clock edge.
        matrixC_flat       = make_matrix(32'h500);
        final_mat_mul_size = 8'd4;
        c_base             = 7'h60;
        c_ready            = 1'b1;
        done_mat_mul       = 1'b1;
        tick();
        tick();
        tick();
        chk("pre_rst_addr", c_addr, 7'h62);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_wen", c_wen, 1'b0);
        chk("abort_addr", c_addr, 7'd0);
        chk("abort_data", c_data, 128'd0);
        chk("abort_done", drain_done, 1'b0);
        done_mat_mul = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("post_rst_idle", c_wen, 1'b0);
        run_case(cases[5], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
